dmem_arbiter_2core: RTL and testbench

Shared data-memory port arbiter sitting directly downstream of two per-core cache_subsystem L1 instances. Accepts refill reads and write-through stores from both L1 miss paths. Grants one requester at a time, round-robin, and drives a single request/ready data-memory interface. Returns the read word or write acknowledge to the granted core, with a timeout/error path.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 22 ++
 rtl/dmem_arbiter_2core.sv | 115 +++++++++++
 tb/tb_dmem_arbiter_2core.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the L1 miss path and the data-memory arbiter.
// Transaction bundle and arbiter state encoding live here.
package cache_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [3:0]            wstrb;
    } mem_txn_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin winner select.
// The core that did not win last time takes a tie.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/dmem_arbiter_2core.sv
// Shares one data-memory port between two L1 miss paths.
// One transaction at a time: IDLE -> BUSY -> DONE, with timeout.
module dmem_arbiter_2core
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    input  logic [1:0][3:0]        wstrb_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    output logic [3:0]             mem_wstrb_o,
    input  logic                   mem_ready_i,
    input  logic [DATA_W-1:0]      mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t       state;
    mem_txn_t         txn;
    logic             owner;
    logic             rr_last;
    logic [CNT_W-1:0] cnt;

    logic [1:0] sel_gnt;
    logic       sel_valid;
    logic       win;

    rr_arbiter_2 u_rr (
        .req     (req_i),
        .rr_last (rr_last),
        .gnt     (sel_gnt),
        .valid   (sel_valid)
    );

    assign win = sel_gnt[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            txn       <= '0;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            cnt       <= '0;
            gnt_o     <= 2'b00;
            rvalid_o  <= 2'b00;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            mem_req_o <= 1'b0;
        end else begin
            gnt_o    <= 2'b00;
            rvalid_o <= 2'b00;
            unique case (state)
                ARB_IDLE: begin
                    if (sel_valid) begin
                        owner     <= win;
                        txn.we    <= we_i[win];
                        txn.addr  <= addr_i[win];
                        txn.wdata <= wdata_i[win];
                        txn.wstrb <= we_i[win] ? wstrb_i[win] : 4'hF;
                        gnt_o     <= sel_gnt;
                        cnt       <= '0;
                        mem_req_o <= 1'b1;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A late ready still beats the timeout on the same cycle
                    if (mem_ready_i) begin
                        rdata_o   <= txn.we ? '0 : mem_rdata_i;
                        err_o     <= 1'b0;
                        mem_req_o <= 1'b0;
                        rvalid_o  <= owner ? 2'b10 : 2'b01;
                        state     <= ARB_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_o   <= '0;
                        err_o     <= 1'b1;
                        mem_req_o <= 1'b0;
                        rvalid_o  <= owner ? 2'b10 : 2'b01;
                        state     <= ARB_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    rr_last <= owner;
                    state   <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign busy_o      = (state != ARB_IDLE);
    assign mem_we_o    = txn.we;
    assign mem_addr_o  = txn.addr;
    assign mem_wdata_o = txn.wdata;
    assign mem_wstrb_o = txn.wstrb;

endmodule

// File: tb/tb_dmem_arbiter_2core.sv
// Scoreboard bench for the two-core data-memory arbiter.
// Expected completions are queued at grant and retired on rvalid.
module tb_dmem_arbiter_2core;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_i;
    logic [1:0]         we_i;
    logic [1:0][AW-1:0] addr_i;
    logic [1:0][DW-1:0] wdata_i;
    logic [1:0][3:0]    wstrb_i;
    logic [1:0]         gnt_o;
    logic [1:0]         rvalid_o;
    logic [DW-1:0]      rdata_o;
    logic               err_o;
    logic               busy_o;
    logic               mem_req_o;
    logic               mem_we_o;
    logic [AW-1:0]      mem_addr_o;
    logic [DW-1:0]      mem_wdata_o;
    logic [3:0]         mem_wstrb_o;
    logic               mem_ready_i;
    logic [DW-1:0]      mem_rdata_i;

    dmem_arbiter_2core #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wstrb_i     (wstrb_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   g_order[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int target[2];
    int gcount[2];
    int gnt_cyc[2];
    int rv_cyc[2];
    int ready_lat;
    int busy_cnt;
    int last_g;
    bit alt_chk;
    bit stray;
    logic [31:0] rd_word;

    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            if (gnt_o[i]) begin
                gcount[i]++;
                gnt_cyc[i] = cyc;
                g_order.push_back(i);
                if (alt_chk && last_g >= 0)
                    check("alternate", 64'(i), 64'(1 - last_g));
                last_g    = i;
                exp_we    = we_i[i];
                exp_addr  = addr_i[i];
                exp_wdata = wdata_i[i];
                exp_wstrb = we_i[i] ? wstrb_i[i] : 4'hF;
                lat       = (ready_lat < TO) ? ready_lat : TO - 1;
                e.core    = i;
                e.err     = (ready_lat >= TO);
                e.rdata   = (we_i[i] || e.err) ? 32'h0 : rd_word;
                e.cyc     = cyc + lat + 1;
                sb.push_back(e);
            end
        end
        if (mem_req_o) begin
            check("mem_ctl", {mem_we_o, mem_addr_o, mem_wstrb_o},
                  {exp_we, exp_addr, exp_wstrb});
            check("mem_wdata", mem_wdata_o, exp_wdata);
        end
        if (rvalid_o != 2'b00) begin
            if (sb.size() == 0) begin
                check("rv_unexpected", rvalid_o, 0);
            end else begin
                e = sb.pop_front();
                rv_cyc[e.core] = cyc;
                check("rv_core", rvalid_o, 64'(2'b01 << e.core));
                check("rv_rdata", rdata_o, e.rdata);
                check("rv_err", err_o, e.err);
                check("rv_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (mem_req_o) begin
            mem_ready_i = (busy_cnt == ready_lat);
            mem_rdata_i = mem_ready_i ? rd_word : (32'h5A5A_0000 ^ 32'(busy_cnt));
            busy_cnt++;
        end else begin
            busy_cnt    = 0;
            mem_ready_i = stray;
            mem_rdata_i = 32'hFFFF_FFFF;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++)
            if (req_i[i] && gcount[i] >= target[i])
                req_i[i] = 1'b0;
    endtask

    task automatic start_req(int c, logic we, logic [9:0] a,
                             logic [31:0] d, logic [3:0] s, int n);
        we_i[c]    = we;
        addr_i[c]  = a;
        wdata_i[c] = d;
        wstrb_i[c] = s;
        target[c]  = gcount[c] + n;
        req_i[c]   = 1'b1;
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (!(sb.size() == 0 && req_i == 2'b00 && !busy_o) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget)
            check("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int g0;
        int g1;
        reset       = 1'b0;
        req_i       = '0;
        we_i        = '0;
        addr_i      = '0;
        wdata_i     = '0;
        wstrb_i     = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        ready_lat   = 0;
        rd_word     = '0;
        stray       = 1'b0;
        alt_chk     = 1'b0;
        last_g      = -1;
        busy_cnt    = 0;
        for (int i = 0; i < 2; i++) begin
            target[i]  = 0;
            gcount[i]  = 0;
            gnt_cyc[i] = 0;
            rv_cyc[i]  = 0;
        end

        repeat (2) step();
        check("rst_ctl", {gnt_o, rvalid_o, err_o, busy_o, mem_req_o, mem_we_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_mem", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, 0);
        reset = 1'b1;
        repeat (2) step();

        // reset while a read is stuck in BUSY
        ready_lat = 1000;
        start_req(0, 1'b0, 10'h004, 32'h0, 4'h0, 1);
        c0 = cyc;
        while (cyc < c0 + 3) step();
        check("busy_pre", {busy_o, mem_req_o}, 2'b11);
        g0 = gcount[0];
        #2 reset = 1'b0;
        #1;
        check("rst_async_req", mem_req_o, 0);
        check("rst_async_busy", busy_o, 0);
        sb.delete();
        repeat (2) step();
        reset = 1'b1;
        repeat (4) step();
        check("post_rst_busy", busy_o, 0);
        check("post_rst_nogrant", 64'(gcount[0]), 64'(g0));

        // simultaneous requests straight after reset
        ready_lat = 0;
        rd_word   = 32'h1234_5678;
        g_order.delete();
        start_req(0, 1'b0, 10'h011, 32'h0, 4'h0, 1);
        start_req(1, 1'b0, 10'h022, 32'h0, 4'h0, 1);
        drain(40);
        check("sim_first", 64'(g_order.size() > 0 ? g_order[0] : -1), 0);
        check("sim_rv_gap", 64'(rv_cyc[1] - rv_cyc[0]), 3);

        // single read from core1
        ready_lat = 2;
        rd_word   = 32'hDEAD_BEEF;
        start_req(1, 1'b0, 10'h1F0, 32'h0, 4'h0, 1);
        c0 = cyc;
        drain(40);
        check("rd_gnt_lat", 64'(gnt_cyc[1] - c0), 1);
        check("rd_rv_lat", 64'(rv_cyc[1] - c0), 4);

        // stray ready while idle must do nothing
        stray = 1'b1;
        repeat (3) step();
        stray = 1'b0;
        step();
        check("stray_idle", {busy_o, mem_req_o}, 0);

        // sustained contention
        ready_lat = 1;
        rd_word   = 32'hCAFE_0001;
        alt_chk   = 1'b1;
        last_g    = -1;
        g0        = gcount[0];
        g1        = gcount[1];
        start_req(0, 1'b0, 10'h100, 32'h0, 4'h0, 4);
        start_req(1, 1'b0, 10'h200, 32'h0, 4'h0, 4);
        drain(200);
        alt_chk = 1'b0;
        check("cont_cnt0", 64'(gcount[0] - g0), 4);
        check("cont_cnt1", 64'(gcount[1] - g1), 4);

        // byte store
        ready_lat = 2;
        rd_word   = 32'h7777_7777;
        start_req(0, 1'b1, 10'h023, 32'h0000_00AB, 4'b1000, 1);
        drain(40);

        // timeout, then ready on the final BUSY cycle
        ready_lat = 1000;
        start_req(0, 1'b0, 10'h040, 32'h0, 4'h0, 1);
        drain(40);
        check("to_lat", 64'(rv_cyc[0] - gnt_cyc[0]), 4);
        ready_lat = 3;
        rd_word   = 32'h0BAD_F00D;
        start_req(0, 1'b0, 10'h041, 32'h0, 4'h0, 1);
        drain(40);
        check("late_rdy_lat", 64'(rv_cyc[0] - gnt_cyc[0]), 4);

        repeat (2) step();
        check("sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
